// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson-code receive path: FSM encoding,
// default width and the index-width derivation.
package johnson_pkg;

    localparam int N_DEFAULT = 4;

    typedef enum logic [1:0] {
        ACQ     = 2'd0,
        CONFIRM = 2'd1,
        LOCK    = 2'd2
    } state_t;

    // A Johnson code of width n walks 2n states, so the index needs clog2(2n) bits.
    function automatic int index_width(input int n);
        return $clog2(2 * n);
    endfunction

    localparam int IW_DEFAULT = index_width(N_DEFAULT);

endpackage

// File: rtl/johnson_code_check.sv
// Combinational Johnson-code classifier: flags legal codes and converts
// them to a binary phase index. Reusable by any monitor on the same bus.
import johnson_pkg::*;

module johnson_code_check #(
    parameter int N  = N_DEFAULT,
    parameter int IW = index_width(N)
) (
    input  logic [N-1:0]  code,
    output logic          legal,
    output logic [IW-1:0] index
);

    logic [N-1:0] norm;
    logic [IW:0]  pop;

    // Inverting MSB=1 codes turns "ones packed at the top" into "ones packed at
    // the bottom", so one contiguity test covers both halves of the cycle.
    always_comb begin
        norm  = code[N-1] ? ~code : code;
        legal = ((norm & (norm + N'(1))) == '0);
        pop   = '0;
        for (int i = 0; i < N; i++) begin
            pop = pop + (IW+1)'(code[i]);
        end
        index = code[N-1] ? IW'((IW+1)'(2 * N) - pop) : IW'(pop);
    end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson bus receiver: decodes each strobed sample, tracks sequence lock,
// and reports wraps, illegal codes and continuity breaks.
import johnson_pkg::*;

module johnson_decoder #(
    parameter int N    = N_DEFAULT,
    parameter int ERRW = 8,
    parameter int IW   = index_width(N)
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            en,
    input  logic [N-1:0]    johnson_in,
    output logic [IW-1:0]   index_out,
    output logic            locked,
    output logic            valid_out,
    output logic            illegal_err,
    output logic            seq_err,
    output logic            wrap,
    output logic [ERRW-1:0] err_count
);

    localparam logic [IW-1:0] LAST_INDEX = IW'(2 * N - 1);
    localparam logic [IW:0]   MODULUS    = (IW+1)'(2 * N);

    state_t          state;
    state_t          next_state;
    logic            legal;
    logic [IW-1:0]   sample_index;
    logic [IW:0]     diff;
    logic            in_step;

    logic [IW-1:0]   index_d;
    logic            valid_d;
    logic            illegal_d;
    logic            seq_d;
    logic            wrap_d;
    logic [ERRW-1:0] err_d;

    johnson_code_check #(
        .N  (N),
        .IW (IW)
    ) u_check (
        .code  (johnson_in),
        .legal (legal),
        .index (sample_index)
    );

    // index_out always holds the last accepted index, so it is the step reference.
    always_comb begin
        diff = (IW+1)'(sample_index) + MODULUS - (IW+1)'(index_out);
        if (diff >= MODULUS) begin
            diff = diff - MODULUS;
        end
        in_step = (diff == '0) || (diff == (IW+1)'(1));
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= ACQ;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (en) begin
            if (!legal) begin
                next_state = ACQ;
            end else begin
                case (state)
                    ACQ:     next_state = CONFIRM;
                    CONFIRM: next_state = in_step ? LOCK : CONFIRM;
                    LOCK:    next_state = in_step ? LOCK : CONFIRM;
                    default: next_state = ACQ;
                endcase
            end
        end
    end

    always_comb begin
        valid_d   = en && legal;
        illegal_d = en && !legal;
        seq_d     = en && legal && (state == LOCK) && !in_step;
        wrap_d    = en && legal && (state == LOCK) &&
                    (index_out == LAST_INDEX) && (sample_index == '0);
        index_d   = (en && legal) ? sample_index : index_out;
        err_d     = err_count;
        if ((illegal_d || seq_d) && (err_count != '1)) begin
            err_d = err_count + ERRW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            index_out   <= '0;
            valid_out   <= 1'b0;
            illegal_err <= 1'b0;
            seq_err     <= 1'b0;
            wrap        <= 1'b0;
            err_count   <= '0;
        end else begin
            index_out   <= index_d;
            valid_out   <= valid_d;
            illegal_err <= illegal_d;
            seq_err     <= seq_d;
            wrap        <= wrap_d;
            err_count   <= err_d;
        end
    end

    assign locked = (state == LOCK);

endmodule
